// File: rtl/cordic_seq_pkg.sv
// Shared types and constants for the CORDIC batch sequencer.
//   seq_state_t  : sequencer FSM states
//   CORDIC_DW    : core read-data width
//   DEF_DWELL / DEF_TIMEOUT : defaults for a 50 MHz clock
//   cnt_w()      : counter width able to hold n-1 (at least 1 bit)
package cordic_seq_pkg;

  localparam int unsigned CORDIC_DW   = 32;
  localparam int unsigned DEF_DWELL   = 50_000_000;
  localparam int unsigned DEF_TIMEOUT = 1_000_000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_READ,
    S_HOLD,
    S_ERROR
  } seq_state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_batch_sequencer_if.sv
// Run/read interface between the sequencer and the cordic_processor core.
//   master (sequencer): drives cp_run, cp_select, cp_addr; samples cp_done, cp_data
//   slave  (core)     : the reverse
interface cordic_batch_sequencer_if #(
  parameter int unsigned ADDR_W = 8
) ();
  import cordic_seq_pkg::*;

  logic                 cp_run;
  logic                 cp_select;
  logic [ADDR_W-1:0]    cp_addr;
  logic                 cp_done;
  logic [CORDIC_DW-1:0] cp_data;

  modport master (output cp_run, cp_select, cp_addr, input cp_done, cp_data);
  modport slave  (input cp_run, cp_select, cp_addr, output cp_done, cp_data);
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
//   clk, rst_n : clock, async active-low reset
//   d_i        : raw asynchronous level
//   pulse_o    : one-cycle pulse per rising edge of d_i
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);

  // [1:0] synchronize, [2] remembers the previous synchronized level
  logic [2:0] sync_q;
  logic       pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], d_i};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cordic_batch_sequencer.sv
// Sequences one CORDIC batch: run pulse, wait for Done (with timeout),
// then read NUM_RESULTS words and hold each for display (timed or manual).
//   clk, rst_n            : clock, async active-low reset
//   start_i, step_i       : raw async requests (edge-triggered)
//   auto_i                : 1 = timed dwell, 0 = step per word
//   cp                    : core run/select/addr/done/data interface
//   res_data/res_addr     : last captured word and its address
//   res_valid, batch_done : one-cycle pulses
//   busy, timeout_err     : batch in progress, sticky timeout flag
module cordic_batch_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned NUM_RESULTS = 4,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned DWELL       = DEF_DWELL,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    step_i,
  input  logic                    auto_i,
  cordic_batch_sequencer_if.master cp,
  output logic [CORDIC_DW-1:0]    res_data,
  output logic [ADDR_W-1:0]       res_addr,
  output logic                    res_valid,
  output logic                    busy,
  output logic                    batch_done,
  output logic                    timeout_err
);

  localparam int unsigned TMR_W  = cnt_w(TIMEOUT);
  localparam int unsigned LAT_W  = cnt_w(RD_LAT);
  localparam int unsigned DWL_W  = cnt_w(DWELL);
  localparam int unsigned WORD_W = cnt_w(NUM_RESULTS);

  logic start_p, step_p;

  sync_edge_detect u_start_sync (.clk(clk), .rst_n(rst_n), .d_i(start_i), .pulse_o(start_p));
  sync_edge_detect u_step_sync  (.clk(clk), .rst_n(rst_n), .d_i(step_i),  .pulse_o(step_p));

  seq_state_t           state_q;
  logic [TMR_W-1:0]     timer_q;
  logic [LAT_W-1:0]     lat_q;
  logic [DWL_W-1:0]     dwell_q;
  logic [WORD_W-1:0]    word_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 auto_q;
  logic                 run_q, select_q, busy_q, done_q, valid_q, err_q;
  logic [CORDIC_DW-1:0] res_data_q;
  logic [ADDR_W-1:0]    res_addr_q;
  logic                 hold_exit;

  // HOLD ends on dwell expiry (auto latched at entry) or a step edge
  assign hold_exit = auto_q ? (dwell_q == '0) : step_p;

  // Sequencer FSM; every output is set on the transition into its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      lat_q      <= '0;
      dwell_q    <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      auto_q     <= 1'b0;
      run_q      <= 1'b0;
      select_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      res_data_q <= '0;
      res_addr_q <= '0;
    end else begin
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start_p) begin
            state_q <= S_LAUNCH;
            run_q   <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT_DONE;
          timer_q <= TMR_W'(TIMEOUT - 1);
        end
        S_WAIT_DONE: begin
          // Done is checked before expiry so a coincident Done still wins
          if (cp.cp_done) begin
            state_q  <= S_READ;
            addr_q   <= ADDR_W'(BASE_ADDR);
            select_q <= 1'b1;
            lat_q    <= LAT_W'(RD_LAT - 1);
            word_q   <= '0;
          end else if (timer_q == '0) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        S_READ: begin
          if (lat_q == '0) begin
            state_q    <= S_HOLD;
            res_data_q <= cp.cp_data;
            res_addr_q <= addr_q;
            valid_q    <= 1'b1;
            auto_q     <= auto_i;
            dwell_q    <= DWL_W'(DWELL - 1);
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        S_HOLD: begin
          if (hold_exit) begin
            // Word count is separate from addr so address wrap is harmless
            if (word_q == WORD_W'(NUM_RESULTS - 1)) begin
              state_q  <= S_IDLE;
              done_q   <= 1'b1;
              select_q <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              state_q <= S_READ;
              addr_q  <= addr_q + ADDR_W'(1);
              word_q  <= word_q + WORD_W'(1);
              lat_q   <= LAT_W'(RD_LAT - 1);
            end
          end else if (auto_q) begin
            dwell_q <= dwell_q - DWL_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cp.cp_run    = run_q;
  assign cp.cp_select = select_q;
  assign cp.cp_addr   = addr_q;
  assign res_data     = res_data_q;
  assign res_addr     = res_addr_q;
  assign res_valid    = valid_q;
  assign busy         = busy_q;
  assign batch_done   = done_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_cordic_batch_sequencer.sv
module tb_cordic_batch_sequencer;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned BASE_ADDR   = 254;
  localparam int unsigned NUM_RESULTS = 4;
  localparam int unsigned RD_LAT      = 2;
  localparam int unsigned DWELL       = 4;
  localparam int unsigned TIMEOUT     = 16;
  localparam int          BUDGET      = 3000;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic clk, rst_n, start_i, step_i, auto_i;
  logic [31:0]       res_data;
  logic [ADDR_W-1:0] res_addr;
  logic res_valid, busy, batch_done, timeout_err;

  cordic_batch_sequencer_if #(.ADDR_W(ADDR_W)) cp_bus ();

  cordic_batch_sequencer #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .NUM_RESULTS(NUM_RESULTS),
    .RD_LAT(RD_LAT), .DWELL(DWELL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .step_i(step_i), .auto_i(auto_i),
    .cp(cp_bus), .res_data(res_data), .res_addr(res_addr), .res_valid(res_valid),
    .busy(busy), .batch_done(batch_done), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   run_cnt = 0, bd_cnt = 0, rv_cnt = 0;
  int   exp_runs = 0, exp_bd = 0;
  int   cyc = 0, run_cyc = 0, te_cyc = 0;
  logic prev_run = 1'b0, prev_te = 1'b0;
  int unsigned done_dly = 5;
  int unsigned core_cnt;
  bit   cur_ok;

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return 32'(a) * 32'h1111_1111;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core model: Done rises done_dly cycles after the run pulse, data one register behind addr
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp_bus.cp_done <= 1'b0;
      cp_bus.cp_data <= '0;
      core_cnt       <= 0;
    end else begin
      cp_bus.cp_data <= word_of(cp_bus.cp_addr);
      if (cp_bus.cp_run) begin
        core_cnt       <= done_dly;
        cp_bus.cp_done <= 1'b0;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) cp_bus.cp_done <= 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (cp_bus.cp_run) begin
        check("run_single_cycle", 32'(prev_run), 32'd0);
        run_cnt++;
        run_cyc = cyc;
      end
      prev_run = cp_bus.cp_run;
      if (timeout_err && !prev_te) te_cyc = cyc;
      prev_te = timeout_err;
      if (batch_done) bd_cnt++;
      if (res_valid) begin
        rv_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_res_valid: got capture at addr %0d expected none", res_addr);
        end else begin
          e = exp_q.pop_front();
          check("res_addr", 32'(res_addr), 32'(e.addr));
          check("res_data", res_data, e.data);
          check("select_at_capture", 32'(cp_bus.cp_select), 32'd1);
        end
      end
    end else begin
      prev_run = 1'b0;
      prev_te  = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    repeat (4) tick();
    start_i = 1'b0;
    repeat (2) tick();
  endtask

  // Issue a batch and queue its expected captures
  task automatic start_batch(input bit a, input int unsigned dly);
    auto_i   = a;
    done_dly = dly;
    cur_ok   = (dly + 1 <= TIMEOUT);
    if (cur_ok) begin
      for (int k = 0; k < int'(NUM_RESULTS); k++) begin
        exp_t e;
        e.addr = ADDR_W'(BASE_ADDR + k);
        e.data = word_of(e.addr);
        exp_q.push_back(e);
      end
      exp_bd++;
    end
    exp_runs++;
    pulse_start();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < BUDGET) begin
      if (!auto_i) step_i = ((n % 8) < 3);
      tick();
      n++;
    end
    step_i = 1'b0;
    if (n >= BUDGET) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic finish_batch();
    wait_idle();
    repeat (3) tick();
    check("busy_after", 32'(busy), 32'd0);
    check("timeout_err_after", 32'(timeout_err), 32'(!cur_ok));
    check("run_count", 32'(run_cnt), 32'(exp_runs));
    check("batch_done_count", 32'(bd_cnt), 32'(exp_bd));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cp_run"}, 32'(cp_bus.cp_run), 32'd0);
    check({tag, "_cp_select"}, 32'(cp_bus.cp_select), 32'd0);
    check({tag, "_cp_addr"}, 32'(cp_bus.cp_addr), 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_batch_done"}, 32'(batch_done), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #(BUDGET * 200 * 10);
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    int base_rv;
    int n;
    rst_n = 1'b0; start_i = 1'b0; step_i = 1'b0; auto_i = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    release_reset();

    // Auto batch; addresses wrap 254,255,0,1
    start_batch(1'b1, 10);
    finish_batch();

    // No Done inside the window -> timeout after TIMEOUT wait cycles
    start_batch(1'b1, TIMEOUT);
    finish_batch();
    check("timeout_latency", 32'(te_cyc - run_cyc), 32'(TIMEOUT + 1));

    // Done coincides with timer expiry; retry also clears the flag
    start_batch(1'b1, TIMEOUT - 1);
    finish_batch();

    // Manual: first word holds until a step; a long step level advances once
    base_rv = rv_cnt;
    start_batch(1'b0, 3);
    n = 0;
    while (rv_cnt == base_rv && n < BUDGET) begin tick(); n++; end
    repeat (20) tick();
    check("manual_hold_count", 32'(rv_cnt - base_rv), 32'd1);
    check("manual_hold_addr", 32'(res_addr), 32'(BASE_ADDR));
    step_i = 1'b1;
    repeat (100) tick();
    step_i = 1'b0;
    repeat (5) tick();
    check("held_step_once", 32'(rv_cnt - base_rv), 32'd2);
    check("held_step_addr", 32'(res_addr), 32'((BASE_ADDR + 1) % 256));
    finish_batch();

    // Random batches with an ignored start edge while busy
    for (int i = 0; i < 16; i++) begin
      start_batch(1'($urandom_range(0, 1)), $urandom_range(1, TIMEOUT + 4));
      if (busy) pulse_start();
      finish_batch();
    end

    // Reset while holding a word in manual mode
    base_rv = rv_cnt;
    start_batch(1'b0, 4);
    n = 0;
    while (rv_cnt == base_rv && n < BUDGET) begin tick(); n++; end
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_hold");
    exp_q.delete();
    exp_bd--;
    release_reset();

    // Reset in the LAUNCH cycle kills the run pulse
    auto_i = 1'b1; done_dly = 5;
    start_i = 1'b1;
    n = 0;
    while (!cp_bus.cp_run && n < 20) begin tick(); n++; end
    check("launch_seen", 32'(cp_bus.cp_run), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_launch");
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();

    // Clean batch after the resets
    start_batch(1'b1, 5);
    finish_batch();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
